// File: rtl/ram_1w_1rs_port_ctrl.sv
// Two-requester access controller for a 1-write / 1-synchronous-read RAM.
// Round-robin arbitration of two writers onto the RAM write port and two
// readers onto the RAM read port. The RAM output register doubles as the
// single response slot: a stalled response is held by keeping ram_rd_en low.
//
// Ports:
//   clk, resetn                          clock, async active-low reset
//   wN_valid/ready/addr/data/mask        write requesters (N = 0,1)
//   rN_cmd_valid/ready/addr              read command streams
//   rN_rsp_valid/ready/data              read response streams
//   ram_wr_en/addr/data/mask             RAM write port
//   ram_rd_en/addr, ram_rd_data          RAM read port (1-cycle latency)
module ram_1w_1rs_port_ctrl #(
    parameter int unsigned ADDR_WIDTH      = 8,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned MASK_WIDTH      = 4,
    parameter bit          COLLISION_STALL = 1'b1
) (
    input  logic                  clk,
    input  logic                  resetn,

    input  logic                  w0_valid,
    output logic                  w0_ready,
    input  logic [ADDR_WIDTH-1:0] w0_addr,
    input  logic [DATA_WIDTH-1:0] w0_data,
    input  logic [MASK_WIDTH-1:0] w0_mask,

    input  logic                  w1_valid,
    output logic                  w1_ready,
    input  logic [ADDR_WIDTH-1:0] w1_addr,
    input  logic [DATA_WIDTH-1:0] w1_data,
    input  logic [MASK_WIDTH-1:0] w1_mask,

    input  logic                  r0_cmd_valid,
    output logic                  r0_cmd_ready,
    input  logic [ADDR_WIDTH-1:0] r0_cmd_addr,
    output logic                  r0_rsp_valid,
    input  logic                  r0_rsp_ready,
    output logic [DATA_WIDTH-1:0] r0_rsp_data,

    input  logic                  r1_cmd_valid,
    output logic                  r1_cmd_ready,
    input  logic [ADDR_WIDTH-1:0] r1_cmd_addr,
    output logic                  r1_rsp_valid,
    input  logic                  r1_rsp_ready,
    output logic [DATA_WIDTH-1:0] r1_rsp_data,

    output logic                  ram_wr_en,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr,
    output logic [DATA_WIDTH-1:0] ram_wr_data,
    output logic [MASK_WIDTH-1:0] ram_wr_mask,
    output logic                  ram_rd_en,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    input  logic [DATA_WIDTH-1:0] ram_rd_data
);

    // Arbitration pointers and response-slot tracking
    logic wr_last_q, wr_last_d;
    logic rd_last_q, rd_last_d;
    logic slot_valid_q, slot_valid_d;
    logic slot_id_q, slot_id_d;

    logic                  wr_any;
    logic                  wr_gnt;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic                  rd_any;
    logic                  rd_cand;
    logic [ADDR_WIDTH-1:0] cand_addr;
    logic                  slot_rsp_ready;
    logic                  rsp_accept;
    logic                  slot_free;
    logic                  collide;
    logic                  issue;

    // Arbitration, issue decision and next-state
    always_comb begin
        wr_last_d    = wr_last_q;
        rd_last_d    = rd_last_q;
        slot_valid_d = slot_valid_q;
        slot_id_d    = slot_id_q;

        // Write side: sole requester wins, ties go to the port not served last
        wr_any  = w0_valid | w1_valid;
        wr_gnt  = (w0_valid & w1_valid) ? ~wr_last_q : w1_valid;
        wr_addr = wr_gnt ? w1_addr : w0_addr;

        ram_wr_en   = resetn & wr_any;
        ram_wr_addr = wr_addr;
        ram_wr_data = wr_gnt ? w1_data : w0_data;
        ram_wr_mask = wr_gnt ? w1_mask : w0_mask;
        w0_ready    = resetn & w0_valid & ~wr_gnt;
        w1_ready    = resetn & w1_valid & wr_gnt;

        if (wr_any) begin
            wr_last_d = wr_gnt;
        end

        // Read side: candidate chosen the same way as writes
        rd_any    = r0_cmd_valid | r1_cmd_valid;
        rd_cand   = (r0_cmd_valid & r1_cmd_valid) ? ~rd_last_q : r1_cmd_valid;
        cand_addr = rd_any ? (rd_cand ? r1_cmd_addr : r0_cmd_addr) : ADDR_WIDTH'(0);

        slot_rsp_ready = slot_id_q ? r1_rsp_ready : r0_rsp_ready;
        rsp_accept     = slot_valid_q & slot_rsp_ready;
        slot_free      = ~slot_valid_q | slot_rsp_ready;

        // A same-address write this cycle would race the read; retry next cycle
        collide = COLLISION_STALL & wr_any & (wr_addr == cand_addr);
        issue   = resetn & rd_any & slot_free & ~collide;

        ram_rd_en    = issue;
        ram_rd_addr  = cand_addr;
        r0_cmd_ready = issue & ~rd_cand;
        r1_cmd_ready = issue & rd_cand;

        r0_rsp_valid = resetn & slot_valid_q & ~slot_id_q;
        r1_rsp_valid = resetn & slot_valid_q & slot_id_q;
        r0_rsp_data  = ram_rd_data;
        r1_rsp_data  = ram_rd_data;

        if (issue) begin
            rd_last_d    = rd_cand;
            slot_valid_d = 1'b1;
            slot_id_d    = rd_cand;
        end else if (rsp_accept) begin
            slot_valid_d = 1'b0;
        end
    end

    // State registers; pointers reset so port 0 wins the first tie
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_last_q    <= 1'b1;
            rd_last_q    <= 1'b1;
            slot_valid_q <= 1'b0;
            slot_id_q    <= 1'b0;
        end else begin
            wr_last_q    <= wr_last_d;
            rd_last_q    <= rd_last_d;
            slot_valid_q <= slot_valid_d;
            slot_id_q    <= slot_id_d;
        end
    end

endmodule

// File: tb/tb_ram_1w_1rs_port_ctrl.sv
// Testbench for ram_1w_1rs_port_ctrl: behavioral RAM on the RAM side, a shadow
// memory updated from requester-side write handshakes, and per-requester
// queues of expected read data popped on response handshakes.
module tb_ram_1w_1rs_port_ctrl;

    localparam int unsigned AW = 8;
    localparam int unsigned DW = 32;
    localparam int unsigned MW = 4;

    logic          clk;
    logic          resetn;
    logic          w0_valid, w0_ready, w1_valid, w1_ready;
    logic [AW-1:0] w0_addr, w1_addr;
    logic [DW-1:0] w0_data, w1_data;
    logic [MW-1:0] w0_mask, w1_mask;
    logic          r0_cmd_valid, r0_cmd_ready, r1_cmd_valid, r1_cmd_ready;
    logic [AW-1:0] r0_cmd_addr, r1_cmd_addr;
    logic          r0_rsp_valid, r0_rsp_ready, r1_rsp_valid, r1_rsp_ready;
    logic [DW-1:0] r0_rsp_data, r1_rsp_data;
    logic          ram_wr_en, ram_rd_en;
    logic [AW-1:0] ram_wr_addr, ram_rd_addr;
    logic [DW-1:0] ram_wr_data, ram_rd_data;
    logic [MW-1:0] ram_wr_mask;

    int n_tests;
    int n_fail;

    logic [DW-1:0] ram_mem [256];
    logic [DW-1:0] shadow  [256];
    logic [DW-1:0] q0 [$];
    logic [DW-1:0] q1 [$];

    ram_1w_1rs_port_ctrl #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW), .COLLISION_STALL(1'b1)
    ) dut (
        .clk(clk), .resetn(resetn),
        .w0_valid(w0_valid), .w0_ready(w0_ready), .w0_addr(w0_addr),
        .w0_data(w0_data), .w0_mask(w0_mask),
        .w1_valid(w1_valid), .w1_ready(w1_ready), .w1_addr(w1_addr),
        .w1_data(w1_data), .w1_mask(w1_mask),
        .r0_cmd_valid(r0_cmd_valid), .r0_cmd_ready(r0_cmd_ready), .r0_cmd_addr(r0_cmd_addr),
        .r0_rsp_valid(r0_rsp_valid), .r0_rsp_ready(r0_rsp_ready), .r0_rsp_data(r0_rsp_data),
        .r1_cmd_valid(r1_cmd_valid), .r1_cmd_ready(r1_cmd_ready), .r1_cmd_addr(r1_cmd_addr),
        .r1_rsp_valid(r1_rsp_valid), .r1_rsp_ready(r1_rsp_ready), .r1_rsp_data(r1_rsp_data),
        .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
        .ram_wr_mask(ram_wr_mask), .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr),
        .ram_rd_data(ram_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioral RAM: byte-masked write, registered read that holds when idle
    always @(posedge clk) begin
        if (ram_wr_en) begin
            for (int i = 0; i < int'(MW); i++) begin
                if (ram_wr_mask[i]) ram_mem[ram_wr_addr][8*i +: 8] <= ram_wr_data[8*i +: 8];
            end
        end
        if (ram_rd_en) ram_rd_data <= ram_mem[ram_rd_addr];
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_v,
                                            input logic [DW-1:0] new_v,
                                            input logic [MW-1:0] m);
        logic [DW-1:0] r;
        r = old_v;
        for (int i = 0; i < int'(MW); i++) begin
            if (m[i]) r[8*i +: 8] = new_v[8*i +: 8];
        end
        return r;
    endfunction

    // Scoreboard: check responses, queue expectations for issued reads, then apply writes
    always @(negedge clk) begin
        if (!resetn) begin
            q0.delete();
            q1.delete();
        end else begin
            if (r0_rsp_valid && r0_rsp_ready) begin
                if (q0.size() == 0) chk("r0_rsp_unexpected", 64'(r0_rsp_data), 64'hX);
                else chk("r0_rsp_data", 64'(r0_rsp_data), 64'(q0.pop_front()));
            end
            if (r1_rsp_valid && r1_rsp_ready) begin
                if (q1.size() == 0) chk("r1_rsp_unexpected", 64'(r1_rsp_data), 64'hX);
                else chk("r1_rsp_data", 64'(r1_rsp_data), 64'(q1.pop_front()));
            end
            if (r0_cmd_valid && r0_cmd_ready) q0.push_back(shadow[r0_cmd_addr]);
            if (r1_cmd_valid && r1_cmd_ready) q1.push_back(shadow[r1_cmd_addr]);
            if (w0_valid && w0_ready) shadow[w0_addr] = merge(shadow[w0_addr], w0_data, w0_mask);
            if (w1_valid && w1_ready) shadow[w1_addr] = merge(shadow[w1_addr], w1_data, w1_mask);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        w0_valid = 1'b0; w1_valid = 1'b0;
        r0_cmd_valid = 1'b0; r1_cmd_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        for (int i = 0; i < 256; i++) begin
            ram_mem[i] = '0;
            shadow[i]  = '0;
        end
        ram_rd_data = '0;
        w0_addr = '0; w0_data = '0; w0_mask = '0;
        w1_addr = '0; w1_data = '0; w1_mask = '0;
        r0_cmd_addr = '0; r1_cmd_addr = '0;
        r0_rsp_ready = 1'b1; r1_rsp_ready = 1'b1;
        idle();

        // Reset: requests present but everything must stay quiet
        resetn = 1'b0;
        w0_valid = 1'b1; r0_cmd_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_w0_ready", 64'(w0_ready), 64'd0);
        chk("rst_r0_cmd_ready", 64'(r0_cmd_ready), 64'd0);
        chk("rst_r0_rsp_valid", 64'(r0_rsp_valid), 64'd0);
        chk("rst_ram_wr_en", 64'(ram_wr_en), 64'd0);
        chk("rst_ram_rd_en", 64'(ram_rd_en), 64'd0);
        cyc();
        resetn = 1'b1;
        idle();
        cyc();

        // Basic write then read
        w0_valid = 1'b1; w0_addr = 8'h10; w0_data = 32'hDEADBEEF; w0_mask = 4'hF;
        @(negedge clk);
        chk("a_w0_ready", 64'(w0_ready), 64'd1);
        chk("a_ram_wr_addr", 64'(ram_wr_addr), 64'h10);
        cyc();
        idle();
        r0_cmd_valid = 1'b1; r0_cmd_addr = 8'h10;
        @(negedge clk);
        chk("a_r0_cmd_ready", 64'(r0_cmd_ready), 64'd1);
        chk("a_ram_rd_en", 64'(ram_rd_en), 64'd1);
        cyc();
        idle();
        @(negedge clk);
        chk("a_r0_rsp_valid", 64'(r0_rsp_valid), 64'd1);
        chk("a_r0_rsp_data", 64'(r0_rsp_data), 64'hDEADBEEF);
        cyc();

        // Partial byte-mask write
        w0_valid = 1'b1; w0_addr = 8'h10; w0_data = 32'h11223344; w0_mask = 4'h3;
        cyc();
        idle();
        r0_cmd_valid = 1'b1; r0_cmd_addr = 8'h10;
        cyc();
        idle();
        @(negedge clk);
        chk("b_r0_rsp_data", 64'(r0_rsp_data), 64'hDEAD3344);
        cyc();

        // Write tie: w0 was granted last, so w1 wins first, then w0
        w0_valid = 1'b1; w0_addr = 8'h30; w0_data = 32'hA0A0A0A0; w0_mask = 4'hF;
        w1_valid = 1'b1; w1_addr = 8'h31; w1_data = 32'hB1B1B1B1; w1_mask = 4'hF;
        @(negedge clk);
        chk("wt_w1_ready", 64'(w1_ready), 64'd1);
        chk("wt_w0_ready", 64'(w0_ready), 64'd0);
        chk("wt_ram_wr_addr", 64'(ram_wr_addr), 64'h31);
        cyc();
        w1_valid = 1'b0;
        @(negedge clk);
        chk("wt_w0_ready_next", 64'(w0_ready), 64'd1);
        cyc();
        idle();

        // Read alternation: r0 served last, so r1, r0, r1, r0
        r0_cmd_valid = 1'b1; r0_cmd_addr = 8'h30;
        r1_cmd_valid = 1'b1; r1_cmd_addr = 8'h31;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("alt_ram_rd_en", 64'(ram_rd_en), 64'd1);
            chk("alt_r1_cmd_ready", 64'(r1_cmd_ready), 64'((i % 2) == 0));
            chk("alt_r0_cmd_ready", 64'(r0_cmd_ready), 64'((i % 2) == 1));
            cyc();
        end
        idle();
        cyc();

        // Response stall holds the slot and blocks the other requester
        r0_cmd_valid = 1'b1; r0_cmd_addr = 8'h10;
        r0_rsp_ready = 1'b0;
        @(negedge clk);
        chk("st_r0_cmd_ready", 64'(r0_cmd_ready), 64'd1);
        cyc();
        r0_cmd_valid = 1'b0;
        r1_cmd_valid = 1'b1; r1_cmd_addr = 8'h31;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("st_r0_rsp_valid", 64'(r0_rsp_valid), 64'd1);
            chk("st_r0_rsp_data", 64'(r0_rsp_data), 64'hDEAD3344);
            chk("st_ram_rd_en", 64'(ram_rd_en), 64'd0);
            chk("st_r1_cmd_ready", 64'(r1_cmd_ready), 64'd0);
            cyc();
        end
        r0_rsp_ready = 1'b1;
        @(negedge clk);
        chk("st_r1_cmd_ready_rel", 64'(r1_cmd_ready), 64'd1);
        chk("st_ram_rd_en_rel", 64'(ram_rd_en), 64'd1);
        cyc();
        idle();
        @(negedge clk);
        chk("st_r1_rsp_valid", 64'(r1_rsp_valid), 64'd1);
        cyc();

        // Same-cycle write/read collision stalls the read one cycle
        w1_valid = 1'b1; w1_addr = 8'h20; w1_data = 32'hCAFEF00D; w1_mask = 4'hF;
        r1_cmd_valid = 1'b1; r1_cmd_addr = 8'h20;
        @(negedge clk);
        chk("col_w1_ready", 64'(w1_ready), 64'd1);
        chk("col_r1_cmd_ready", 64'(r1_cmd_ready), 64'd0);
        chk("col_ram_rd_en", 64'(ram_rd_en), 64'd0);
        cyc();
        w1_valid = 1'b0;
        @(negedge clk);
        chk("col_r1_cmd_ready_retry", 64'(r1_cmd_ready), 64'd1);
        cyc();
        idle();
        @(negedge clk);
        chk("col_r1_rsp_data", 64'(r1_rsp_data), 64'hCAFEF00D);
        cyc();

        // Reset with a held response: valid drops at once, pointers restart
        r0_cmd_valid = 1'b1; r0_cmd_addr = 8'h10;
        r0_rsp_ready = 1'b0;
        cyc();
        idle();
        @(negedge clk);
        chk("rr_r0_rsp_valid_pre", 64'(r0_rsp_valid), 64'd1);
        cyc();
        resetn = 1'b0;
        #1;
        chk("rr_r0_rsp_valid_rst", 64'(r0_rsp_valid), 64'd0);
        @(negedge clk);
        chk("rr_ram_rd_en_rst", 64'(ram_rd_en), 64'd0);
        cyc();
        resetn = 1'b1;
        r0_rsp_ready = 1'b1;
        r0_cmd_valid = 1'b1; r0_cmd_addr = 8'h10;
        r1_cmd_valid = 1'b1; r1_cmd_addr = 8'h31;
        @(negedge clk);
        chk("rr_r0_rsp_valid_post", 64'(r0_rsp_valid), 64'd0);
        chk("rr_first_tie_r0", 64'(r0_cmd_ready), 64'd1);
        chk("rr_first_tie_r1", 64'(r1_cmd_ready), 64'd0);
        cyc();
        @(negedge clk);
        chk("rr_second_r1", 64'(r1_cmd_ready), 64'd1);
        cyc();
        idle();
        for (int i = 0; i < 3; i++) cyc();

        chk("drain_q0", 64'(q0.size()), 64'd0);
        chk("drain_q1", 64'(q1.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
